// File: rtl/led_mux_seq_pkg.sv
// Shared types and constants for the LED mux sequencer.
// Optional ping-pong stepping is enabled with LED_MUX_SEQ_PINGPONG_EN.
package led_mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int               SEL_W   = 3;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

    // Plain up-count with wrap from SEL_MAX back to zero.
    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        logic [SEL_W-1:0] r;
        if (s == SEL_MAX) begin
            r = 3'd0;
        end else begin
            r = s + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_mux_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// one-cycle strobe on each accepted 0->1 change of the button level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta_r;
    logic          sync_r;
    logic          level_r;
    logic          rise_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
            level_r     <= 1'b0;
            rise_r      <= 1'b0;
            cnt_r       <= {CW{1'b0}};
        end else begin
            sync_meta_r <= raw;
            sync_r      <= sync_meta_r;
            if (sync_r == level_r) begin
                cnt_r  <= {CW{1'b0}};
                rise_r <= 1'b0;
            end else if (cnt_r == CNT_MAX) begin
                cnt_r   <= {CW{1'b0}};
                level_r <= sync_r;
                rise_r  <= sync_r;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                rise_r <= 1'b0;
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/led_mux_sequencer.sv
// Timed sequencer for the LED mux selects with run/pause/step/clear control.
// Define LED_MUX_SEQ_PINGPONG_EN for 0..7..0 ping-pong stepping.
module led_mux_sequencer
    import led_mux_seq_pkg::*;
#(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             run_sw,
    input  logic             clr_sw,
    output logic [SEL_W-1:0] sel,
    output logic             step_pulse,
    output logic             running
);

    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic             run_meta_r, run_s, clr_meta_r, clr_s;
    logic             btn_level, btn_rise, btn_evt;
    state_t           state_r, state_next;
    logic [PW-1:0]    pre_r, pre_next;
    logic [SEL_W-1:0] sel_r, sel_next;
    logic             step_r, running_r, tick, adv;
`ifdef LED_MUX_SEQ_PINGPONG_EN
    dir_t             dir_r, dir_next;
`endif

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (btn_level),
        .rise  (btn_rise)
    );

    // The strobe only ever fires together with a freshly accepted high level.
    assign btn_evt = btn_rise & btn_level;
    assign tick    = (pre_r == PRE_MAX);

    // Two-flop synchronizers for the run and clear switches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_meta_r <= 1'b0;
            run_s      <= 1'b0;
            clr_meta_r <= 1'b0;
            clr_s      <= 1'b0;
        end else begin
            run_meta_r <= run_sw;
            run_s      <= run_meta_r;
            clr_meta_r <= clr_sw;
            clr_s      <= clr_meta_r;
        end
    end

    // Next state and advance request; clear wins, then transitions, then advance.
    always_comb begin
        state_next = state_r;
        adv        = 1'b0;
        if (clr_s) begin
            state_next = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (run_s) state_next = RUN;
                    else       state_next = IDLE;
                end
                RUN: begin
                    if (!run_s)    state_next = PAUSE;
                    else if (tick) adv = 1'b1;
                    else           adv = 1'b0;
                end
                PAUSE: begin
                    if (run_s)        state_next = RUN;
                    else if (btn_evt) adv = 1'b1;
                    else              adv = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Prescaler only runs while staying in RUN; it restarts from 0 on entry.
    always_comb begin
        pre_next = {PW{1'b0}};
        if (state_r == RUN && state_next == RUN) begin
            if (tick) pre_next = {PW{1'b0}};
            else      pre_next = pre_r + PW'(1);
        end else begin
            pre_next = {PW{1'b0}};
        end
    end

    // Select update: clear to 0, otherwise step on an accepted advance.
    always_comb begin
        sel_next = sel_r;
`ifdef LED_MUX_SEQ_PINGPONG_EN
        dir_next = dir_r;
        if (clr_s) begin
            sel_next = 3'd0;
            dir_next = UP;
        end else if (adv) begin
            if (dir_r == UP) begin
                if (sel_r == SEL_MAX) begin
                    sel_next = sel_r - 3'd1;
                    dir_next = DOWN;
                end else begin
                    sel_next = sel_r + 3'd1;
                end
            end else begin
                if (sel_r == 3'd0) begin
                    sel_next = 3'd1;
                    dir_next = UP;
                end else begin
                    sel_next = sel_r - 3'd1;
                end
            end
        end else begin
            sel_next = sel_r;
        end
`else
        if (clr_s)    sel_next = 3'd0;
        else if (adv) sel_next = sel_inc(sel_r);
        else          sel_next = sel_r;
`endif
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pre_r     <= {PW{1'b0}};
            sel_r     <= 3'd0;
            step_r    <= 1'b0;
            running_r <= 1'b0;
`ifdef LED_MUX_SEQ_PINGPONG_EN
            dir_r     <= UP;
`endif
        end else begin
            state_r   <= state_next;
            pre_r     <= pre_next;
            sel_r     <= sel_next;
            step_r    <= adv;
            running_r <= (state_next == RUN);
`ifdef LED_MUX_SEQ_PINGPONG_EN
            dir_r     <= dir_next;
`endif
        end
    end

    assign sel        = sel_r;
    assign step_pulse = step_r;
    assign running    = running_r;

endmodule

// File: tb/tb_led_mux_sequencer.sv
// Directed bench for led_mux_sequencer with a step scoreboard (sel value and cycle).
// Honours LED_MUX_SEQ_PINGPONG_EN for the expected step sequence.
module tb_led_mux_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, btn_step, run_sw, clr_sw;
    logic [2:0] sel;
    logic       step_pulse, running;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [2:0] sel;
        int         cyc_at;
    } exp_t;
    exp_t exp_q[$];

    logic [2:0] m_sel = 3'd0;
    logic       m_up  = 1'b1;

    led_mux_sequencer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .run_sw     (run_sw),
        .clr_sw     (clr_sw),
        .sel        (sel),
        .step_pulse (step_pulse),
        .running    (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int target);
        goto(target);
        @(negedge clk);
    endtask

    task automatic push_step(input int at_cyc);
`ifdef LED_MUX_SEQ_PINGPONG_EN
        if (m_up) begin
            if (m_sel == 3'd7) begin
                m_sel = 3'd6;
                m_up  = 1'b0;
            end else begin
                m_sel = m_sel + 3'd1;
            end
        end else begin
            if (m_sel == 3'd0) begin
                m_sel = 3'd1;
                m_up  = 1'b1;
            end else begin
                m_sel = m_sel - 3'd1;
            end
        end
`else
        m_sel = m_sel + 3'd1;
`endif
        exp_q.push_back('{m_sel, at_cyc});
    endtask

    // Every step_pulse must match the next scoreboard entry in value and cycle.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            chk("step_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_sel", 32'(sel), 32'(e.sel));
                chk("step_cycle", 32'(cyc), 32'(e.cyc_at));
            end
        end
    end

    initial begin
        int e0, r, p, b, c, r2, d;
        rst_n    = 1'b0;
        btn_step = 1'b1;
        run_sw   = 1'b1;
        clr_sw   = 1'b1;

        sample_at(3);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_step", 32'(step_pulse), 32'd0);
        rst_n = 1'b1;

        // Clear held after reset; the held button must not move sel in IDLE.
        sample_at(cyc + 6);
        chk("idle_clr_sel", 32'(sel), 32'd0);
        chk("idle_clr_running", 32'(running), 32'd0);
        btn_step = 1'b0;
        goto(cyc + 6);

        // Auto-run with wrap; a button press during RUN is ignored.
        e0 = cyc;
        clr_sw = 1'b0;
        r = e0 + 3;
        for (int k = 1; k <= 13; k++) push_step(r + 4 * k);
        sample_at(e0 + 2);
        chk("run_latency_early", 32'(running), 32'd0);
        sample_at(e0 + 3);
        chk("run_latency", 32'(running), 32'd1);
        goto(r + 20);
        btn_step = 1'b1;
        goto(r + 26);
        btn_step = 1'b0;

        // Drop run so the transition lands on a tick edge: no advance.
        goto(r + 53);
        run_sw = 1'b0;
        p = r + 56;
        sample_at(p);
        chk("pause_running", 32'(running), 32'd0);
        chk("pause_hold_sel", 32'(sel), 32'(m_sel));

        goto(p + 2);
        btn_step = 1'b1;
        goto(p + 3);
        btn_step = 1'b0;
        sample_at(p + 11);
        chk("glitch1_sel", 32'(sel), 32'(m_sel));

        goto(p + 12);
        btn_step = 1'b1;
        goto(p + 14);
        btn_step = 1'b0;
        sample_at(p + 22);
        chk("glitch2_sel", 32'(sel), 32'(m_sel));

        b = p + 24;
        goto(b);
        btn_step = 1'b1;
        push_step(b + 6);
        sample_at(b + 6);
        chk("single_step_sel", 32'(sel), 32'(m_sel));
        btn_step = 1'b0;
        goto(b + 16);
        chk("single_step_held", 32'(sel), 32'(m_sel));

        // Resume, then clear with the prescaler at 2.
        c = cyc;
        run_sw = 1'b1;
        r2 = c + 3;
        for (int k = 1; k <= 5; k++) push_step(r2 + 4 * k);
        goto(r2 + 20);
        clr_sw = 1'b1;
        sample_at(r2 + 22);
        chk("pre_clear_sel", 32'(sel), 32'(m_sel));
        chk("pre_clear_running", 32'(running), 32'd1);
        sample_at(r2 + 23);
        m_sel = 3'd0;
        m_up  = 1'b1;
        chk("clear_sel", 32'(sel), 32'(m_sel));
        chk("clear_running", 32'(running), 32'd0);

        // Restart after clear: first advance 4 cycles after entering RUN.
        goto(r2 + 27);
        d = cyc;
        clr_sw = 1'b0;
        push_step(d + 7);
        sample_at(d + 3);
        chk("restart_running", 32'(running), 32'd1);
        sample_at(d + 10);
        chk("restart_sel", 32'(sel), 32'(m_sel));
        chk("pending_steps", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
